// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - unsigned 8x8 shift-add multiplier that sequences the shared 8-bit ALU
module alu_mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   MultA,
    input  logic [WIDTH-1:0]   MultB,
    input  logic [WIDTH-1:0]   AluOut,
    output logic [WIDTH-1:0]   AluA,
    output logic [WIDTH-1:0]   AluB,
    output logic [2:0]         AluOp,
    output logic               AluEn,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam logic [2:0] MC_ADD = 3'd0;
    localparam logic [2:0] MC_LSR = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHH,
        SHL,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             c_q, c_d;
    logic             hb0_q, hb0_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             alu_en_q, alu_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        c_d     = c_q;
        hb0_d   = hb0_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    mcand_d = MultA;
                    lo_d    = MultB;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = MultB[0] ? ADD : SHH;
                end
            end
            ADD: begin
                // The ALU drops the carry; a wrapped sum is smaller than either addend.
                hi_d    = AluOut;
                c_d     = (AluOut < hi_q);
                state_d = SHH;
            end
            SHH: begin
                hb0_d   = hi_q[0];
                hi_d    = {c_q, AluOut[WIDTH-2:0]};
                c_d     = 1'b0;
                state_d = SHL;
            end
            SHL: begin
                lo_d = {hb0_q, AluOut[WIDTH-2:0]};
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = lo_q[1] ? ADD : SHH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state and next register values.
        alu_en_d = (state_d == ADD) || (state_d == SHH) || (state_d == SHL);
        if (state_d == SHL) begin
            alu_a_d = lo_d;
        end else if (alu_en_d) begin
            alu_a_d = hi_d;
        end else begin
            alu_a_d = '0;
        end
        if (state_d == ADD) begin
            alu_b_d = mcand_d;
        end else if (alu_en_d) begin
            alu_b_d = WIDTH'(1);
        end else begin
            alu_b_d = '0;
        end
        alu_op_d = ((state_d == SHH) || (state_d == SHL)) ? MC_LSR : MC_ADD;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            c_q      <= 1'b0;
            hb0_q    <= 1'b0;
            cnt_q    <= 3'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= MC_ADD;
            alu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            c_q      <= c_d;
            hb0_q    <= hb0_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            alu_en_q <= alu_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign AluA    = alu_a_q;
    assign AluB    = alu_b_q;
    assign AluOp   = alu_op_q;
    assign AluEn   = alu_en_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - scoreboard bench for alu_mul_sequencer with a behavioural ALU
module tb_alu_mul_sequencer;

    localparam logic [2:0] MC_ADD = 3'd0;
    localparam logic [2:0] MC_LSR = 3'd5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  mult_a, mult_b;
    logic [7:0]  alu_out, alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_en, busy, done;
    logic [15:0] product;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          adds;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_mul_sequencer #(.WIDTH(8)) dut (
        .Clk     (clk),
        .Reset_n (reset_n),
        .Start   (start),
        .MultA   (mult_a),
        .MultB   (mult_b),
        .AluOut  (alu_out),
        .AluA    (alu_a),
        .AluB    (alu_b),
        .AluOp   (alu_op),
        .AluEn   (alu_en),
        .Busy    (busy),
        .Done    (done),
        .Product (product)
    );

    always #5 clk = ~clk;

    // Shared ALU: 8-bit add with carry discarded, logical shift right.
    always_comb begin
        case (alu_op)
            MC_ADD:  alu_out = alu_a + alu_b;
            MC_LSR:  alu_out = alu_a >> alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.prod = {8'h00, a} * {8'h00, b};
        e.adds = $countones(b);
        e.lat  = 17 + e.adds;
        sb.push_back(e);
    endtask

    // Drives Start with operands and returns just after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start  = 1'b1;
        mult_a = a;
        mult_b = b;
        push_exp(a, b);
        @(posedge clk);
    endtask

    // mode 0: plain; mode 1: spam Start while busy; mode 2: hold Start and load next operands.
    task automatic wait_done(input int mode, input string name,
                             input logic [7:0] na, input logic [7:0] nb);
        exp_t e;
        int   cyc, en_cnt, add_cnt;
        bit   got;
        cyc = 0; en_cnt = 0; add_cnt = 0; got = 0;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
                end
                if (mode == 2) begin
                    mult_a = na;
                    mult_b = nb;
                    push_exp(na, nb);
                end
            end
            if (mode == 0) begin
                start = 1'b0;
            end else if (mode == 1) begin
                start  = (cyc % 4 == 2);
                mult_a = 8'($urandom);
                mult_b = 8'($urandom);
            end
            if (done === 1'b1) begin
                got = 1;
                if (mode != 2) start = 1'b0;
                n_checks++;
                if (product !== e.prod) begin
                    n_fail++;
                    $display("FAIL %s product: got %h want %h", name, product, e.prod);
                end
                n_checks++;
                if (cyc != e.lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
                end
                n_checks++;
                if (en_cnt != 16 + e.adds || add_cnt != e.adds) begin
                    n_fail++;
                    $display("FAIL %s alu_trace: en %0d adds %0d want en %0d adds %0d",
                             name, en_cnt, add_cnt, 16 + e.adds, e.adds);
                end
            end else if (alu_en === 1'b1) begin
                en_cnt++;
                if (alu_op === MC_ADD) add_cnt++;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: no Done within %0d cycles", name, cyc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        mult_a  = 8'h12;
        mult_b  = 8'h34;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_en !== 1'b0 || product !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: busy %b done %b en %b product %h want 0 0 0 0000",
                     busy, done, alu_en, product);
        end
        n_checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== MC_ADD) begin
            n_fail++;
            $display("FAIL reset_alu: a %h b %h op %0d want 00 00 %0d", alu_a, alu_b, alu_op, MC_ADD);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy %b want 0", busy);
        end
    endtask

    task automatic test_products();
        logic [7:0] ra, rb;
        start_op(8'd13, 8'd11);   wait_done(0, "13x11", 8'h0, 8'h0);
        start_op(8'hFF, 8'hFF);   wait_done(0, "ffxff", 8'h0, 8'h0);
        start_op(8'd200, 8'd200); wait_done(0, "200x200", 8'h0, 8'h0);
        start_op(8'h00, 8'hA5);   wait_done(0, "00xa5", 8'h0, 8'h0);
        start_op(8'hA5, 8'h00);   wait_done(0, "a5x00", 8'h0, 8'h0);
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start_op(ra, rb);
            wait_done(0, "random", 8'h0, 8'h0);
        end
    endtask

    task automatic test_start_ignored();
        start_op(8'd37, 8'd99);
        wait_done(1, "start_spam", 8'h0, 8'h0);
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (product !== 16'(37 * 99) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL product_hold: got %h busy %b want %h busy 0", product, busy, 16'(37 * 99));
            end
        end
    endtask

    task automatic test_back_to_back();
        start_op(8'd7, 8'd6);
        wait_done(2, "b2b_first", 8'd9, 8'd3);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'd42) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy %b done %b product %h want 0 0 002a", busy, done, product);
        end
        @(posedge clk);
        wait_done(0, "b2b_second", 8'h0, 8'h0);
    endtask

    task automatic test_reset_abort();
        int lsr_cnt, cyc;
        lsr_cnt = 0;
        cyc     = 0;
        start_op(8'h37, 8'h5A);
        while (lsr_cnt < 10 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (alu_en === 1'b1 && alu_op === MC_LSR) lsr_cnt++;
        end
        n_checks++;
        if (lsr_cnt != 10) begin
            n_fail++;
            $display("FAIL abort_reach_shl: lsr count %0d want 10", lsr_cnt);
        end
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_en !== 1'b0 || product !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_state: busy %b done %b en %b product %h want 0 0 0 0000",
                     busy, done, alu_en, product);
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: done %b busy %b want 0 0", done, busy);
            end
        end
        start_op(8'd3, 8'd5);
        wait_done(0, "3x5_after_abort", 8'h0, 8'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        mult_a  = 8'h00;
        mult_b  = 8'h00;
        test_reset();
        test_products();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
